// File: rtl/store_buffer_if.sv
// Request/response and data-memory signal bundle for store_buffer.
// The pipeline and memory side uses the master modport. The buffer uses the slave modport.
interface store_buffer_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    // Handshake: a request transfers on any cycle where req_valid && req_ready.
    // req_ready may depend combinationally on the request fields, because of the load hazard check.
    // While a request is stalled, the pipeline holds its fields stable.
    // ld_valid/ld_data answer an accepted load in that same cycle.
    logic                  req_valid;
    logic                  req_write;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [2:0]            req_funct3;
    logic                  req_ready;
    logic                  ld_valid;
    logic [DATA_W-1:0]     ld_data;
    logic                  dm_MemRead;
    logic                  dm_MemWrite;
    logic [DM_ADDRESS-1:0] dm_a;
    logic [DATA_W-1:0]     dm_wd;
    logic [2:0]            dm_Funct3;
    logic [DATA_W-1:0]     dm_rd;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3, dm_rd,
        output req_ready, ld_valid, ld_data,
        output dm_MemRead, dm_MemWrite, dm_a, dm_wd, dm_Funct3
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3, dm_rd,
        input  req_ready, ld_valid, ld_data,
        input  dm_MemRead, dm_MemWrite, dm_a, dm_wd, dm_Funct3
    );
endinterface

// File: rtl/store_buffer.sv
// FIFO store buffer in front of a single-ported data memory; drains in idle memory cycles.
// Optional macro SB_FWD_EN: LW hitting a buffered SW is answered from the youngest matching entry.
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    store_buffer_if.slave              bus,
    output logic [$clog2(DEPTH+1)-1:0] sb_count,
    output logic                       sb_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [2:0] F3_WORD = 3'b010;

    logic [DM_ADDRESS-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0]     ent_data [DEPTH];
    logic [2:0]            ent_f3   [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [PW-1:0]    ent_off [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_hit;
    logic             full;
    logic             hazard;
    logic             fwd_ok;
    logic             ready;
    logic             accept;
    logic             st_acc;
    logic             ld_acc;
    logic             drain;

    assign full = (count == CNT_FULL);

    // An entry is live when its distance from head is below count.
    always_comb begin
        ent_valid = '0;
        ent_hit   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_off[i]   = PW'(i) - head;
            ent_valid[i] = (CW'(ent_off[i]) < count);
            ent_hit[i]   = ent_valid[i] && (ent_addr[i] == bus.req_addr);
        end
    end

    assign hazard = bus.req_valid & ~bus.req_write & (|ent_hit);

`ifdef SB_FWD_EN
    logic              fwd_found;
    logic [2:0]        fwd_f3;
    logic [DATA_W-1:0] fwd_data;

    // Walk back from the newest entry so the youngest matching store wins.
    always_comb begin
        fwd_found = 1'b0;
        fwd_f3    = 3'b000;
        fwd_data  = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!fwd_found && (CW'(k) <= count) &&
                (ent_addr[tail - PW'(k)] == bus.req_addr)) begin
                fwd_found = 1'b1;
                fwd_f3    = ent_f3[tail - PW'(k)];
                fwd_data  = ent_data[tail - PW'(k)];
            end
        end
    end

    assign fwd_ok = hazard & fwd_found & (bus.req_funct3 == F3_WORD) & (fwd_f3 == F3_WORD);
`else
    assign fwd_ok = 1'b0;
`endif

    always_comb begin
        ready = 1'b0;
        if (reset) begin
            ready = 1'b0;
        end else if (bus.req_write) begin
            ready = ~full;
        end else begin
            ready = (~full & ~hazard) | fwd_ok;
        end
    end

    assign bus.req_ready = ready;
    assign accept = bus.req_valid & ready;
    assign st_acc = accept & bus.req_write;
    assign ld_acc = accept & ~bus.req_write;
    // Drain only when the memory port is not needed by an accepted request.
    assign drain = ~reset & (count != '0) & ~accept;

    always_comb begin
        bus.ld_valid    = 1'b0;
        bus.ld_data     = '0;
        bus.dm_MemRead  = 1'b0;
        bus.dm_MemWrite = 1'b0;
        bus.dm_a        = '0;
        bus.dm_wd       = '0;
        bus.dm_Funct3   = 3'b000;
        if (ld_acc) begin
            bus.ld_valid = 1'b1;
            if (fwd_ok) begin
`ifdef SB_FWD_EN
                bus.ld_data = fwd_data;
`endif
            end else begin
                bus.dm_MemRead = 1'b1;
                bus.dm_a       = bus.req_addr;
                bus.dm_Funct3  = bus.req_funct3;
                bus.ld_data    = bus.dm_rd;
            end
        end else if (drain) begin
            bus.dm_MemWrite = 1'b1;
            bus.dm_a        = ent_addr[head];
            bus.dm_wd       = ent_data[head];
            bus.dm_Funct3   = ent_f3[head];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (st_acc) begin
            tail  <= tail + PTR_ONE;
            count <= count + CNT_ONE;
        end else if (drain) begin
            head  <= head + PTR_ONE;
            count <= count - CNT_ONE;
        end
    end

    // Entry payload needs no reset: liveness comes from head/count only.
    always_ff @(posedge clk) begin
        if (st_acc) begin
            ent_addr[tail] <= bus.req_addr;
            ent_data[tail] <= bus.req_wdata;
            ent_f3[tail]   <= bus.req_funct3;
        end
    end

    assign sb_count = reset ? '0 : count;
    assign sb_empty = reset | (count == '0);
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: vector table, memory model, and drain-order scoreboard.
// Compiled without SB_FWD_EN by default; the forwarding vectors are built when it is defined.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic [CW-1:0] sb_count;
    logic          sb_empty;

    store_buffer_if #(.DM_ADDRESS(AW), .DATA_W(DW)) sb_if ();

    store_buffer #(.DEPTH(DEPTH), .DM_ADDRESS(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (sb_if),
        .sb_count (sb_count),
        .sb_empty (sb_empty)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // data memory model
    logic [DW-1:0] mem [512];
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        mem[9'h040] = 32'h0000ABCD;
    end
    always @(posedge clk) if (sb_if.dm_MemWrite) mem[sb_if.dm_a] <= sb_if.dm_wd;
    assign sb_if.dm_rd = mem[sb_if.dm_a];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard: expected drain writes {funct3, addr, data} in FIFO order
    logic [3+AW+DW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (sb_if.dm_MemWrite && sb_if.dm_MemRead) chk("read_and_write", 1, 0);
        if (sb_if.dm_MemWrite) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", {55'd0, sb_if.dm_a}, 64'hFFFF);
            end else begin
                chk("drain_entry", {20'd0, sb_if.dm_Funct3, sb_if.dm_a, sb_if.dm_wd},
                    {20'd0, exp_q.pop_front()});
            end
        end else if (!sb_if.dm_MemRead) begin
            chk("dm_idle_zero", {20'd0, sb_if.dm_Funct3, sb_if.dm_a, sb_if.dm_wd}, 64'd0);
        end
    end

    // vector table
    typedef struct {
        logic          valid;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [2:0]    f3;
        logic          exp_ready;
        logic          exp_ldv;
        logic [DW-1:0] exp_ldd;
        logic          exp_rd;
        logic          exp_wr;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t vecs [64];
    int   nvec = 0;

    task automatic add(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [2:0] f, input logic rdy, input logic ldv, input logic [DW-1:0] ldd,
                       input logic rd, input logic wr, input int cnt);
        vecs[nvec] = '{v, w, a, d, f, rdy, ldv, ldd, rd, wr, CW'(cnt)};
        nvec++;
    endtask

    task automatic sw(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rdy, input logic wr,
                      input int cnt);
        add(1, 1, a, d, 3'b010, rdy, 0, 0, 0, wr, cnt);
    endtask

    task automatic idle(input logic rdy, input logic wr, input int cnt);
        add(0, 0, 0, 0, 3'b000, rdy, 0, 0, 0, wr, cnt);
    endtask

    // driver
    task automatic drive_idle();
        sb_if.req_valid  = 1'b0;
        sb_if.req_write  = 1'b0;
        sb_if.req_addr   = '0;
        sb_if.req_wdata  = '0;
        sb_if.req_funct3 = 3'b000;
    endtask

    // Called at posedge+1; checks combinational outputs mid-cycle, state after the edge.
    task automatic apply(input int idx);
        vec_t v;
        v = vecs[idx];
        sb_if.req_valid  = v.valid;
        sb_if.req_write  = v.write;
        sb_if.req_addr   = v.addr;
        sb_if.req_wdata  = v.wdata;
        sb_if.req_funct3 = v.f3;
        if (v.valid && v.write && v.exp_ready) exp_q.push_back({v.f3, v.addr, v.wdata});
        #1;
        chk($sformatf("v%0d req_ready", idx), {63'd0, sb_if.req_ready}, {63'd0, v.exp_ready});
        chk($sformatf("v%0d ld_valid", idx), {63'd0, sb_if.ld_valid}, {63'd0, v.exp_ldv});
        chk($sformatf("v%0d ld_data", idx), {32'd0, sb_if.ld_data}, {32'd0, v.exp_ldd});
        chk($sformatf("v%0d dm_MemRead", idx), {63'd0, sb_if.dm_MemRead}, {63'd0, v.exp_rd});
        chk($sformatf("v%0d dm_MemWrite", idx), {63'd0, sb_if.dm_MemWrite}, {63'd0, v.exp_wr});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d sb_count", idx), {61'd0, sb_count}, {61'd0, v.exp_cnt});
        chk($sformatf("v%0d sb_empty", idx), {63'd0, sb_empty}, {63'd0, v.exp_cnt == 0});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " req_ready"}, {63'd0, sb_if.req_ready}, 64'd0);
        chk({tag, " ld_valid"}, {63'd0, sb_if.ld_valid}, 64'd0);
        chk({tag, " sb_empty"}, {63'd0, sb_empty}, 64'd1);
        chk({tag, " sb_count"}, {61'd0, sb_count}, 64'd0);
        chk({tag, " dm_ctrl"}, {62'd0, sb_if.dm_MemRead, sb_if.dm_MemWrite}, 64'd0);
    endtask

    localparam logic [2:0] LF3 =
`ifdef SB_FWD_EN
        3'b000;
`else
        3'b010;
`endif

    initial begin
        // test 1: fill, then a fifth store waits one drain
        sw(9'h010, 32'h11111111, 1, 0, 1);
        sw(9'h014, 32'h22222222, 1, 0, 2);
        sw(9'h018, 32'h33333333, 1, 0, 3);
        sw(9'h01C, 32'h44444444, 1, 0, 4);
        sw(9'h020, 32'h55555555, 0, 1, 3);
        sw(9'h020, 32'h55555555, 1, 0, 4);
        // test 2: idle drains in FIFO order
        idle(0, 1, 3);
        idle(1, 1, 2);
        idle(1, 1, 1);
        idle(1, 1, 0);
        // test 3: load hazard stalls until the store drains
        sw(9'h020, 32'hDEADBEEF, 1, 0, 1);
        add(1, 0, 9'h020, 0, 3'b010, 0, 0, 0, 0, 1, 0);
        add(1, 0, 9'h020, 0, 3'b010, 1, 1, 32'hDEADBEEF, 1, 0, 0);
        // test 4: non-hazard load bypasses buffered stores
        sw(9'h050, 32'h00000001, 1, 0, 1);
        sw(9'h054, 32'h00000002, 1, 0, 2);
        add(1, 0, 9'h040, 0, 3'b010, 1, 1, 32'h0000ABCD, 1, 0, 2);
        // test 5: LW after SW to the same address
        sw(9'h030, 32'hCAFEF00D, 1, 0, 3);
`ifdef SB_FWD_EN
        add(1, 0, 9'h030, 0, 3'b010, 1, 1, 32'hCAFEF00D, 0, 0, 3);
`endif
        add(1, 0, 9'h030, 0, LF3, 0, 0, 0, 0, 1, 2);
        add(1, 0, 9'h030, 0, LF3, 0, 0, 0, 0, 1, 1);
        add(1, 0, 9'h030, 0, LF3, 0, 0, 0, 0, 1, 0);
        add(1, 0, 9'h030, 0, LF3, 1, 1, 32'hCAFEF00D, 1, 0, 0);
        // full buffer: a non-hazard load stalls exactly one drain
        sw(9'h060, 32'h60606060, 1, 0, 1);
        sw(9'h064, 32'h64646464, 1, 0, 2);
        sw(9'h068, 32'h68686868, 1, 0, 3);
        sw(9'h06C, 32'h6C6C6C6C, 1, 0, 4);
        add(1, 0, 9'h040, 0, 3'b010, 0, 0, 0, 0, 1, 3);
        add(1, 0, 9'h040, 0, 3'b010, 1, 1, 32'h0000ABCD, 1, 0, 3);
        idle(1, 1, 2);
        idle(1, 1, 1);
        idle(1, 1, 0);
        // stores that reset will discard
        sw(9'h070, 32'h70707070, 1, 0, 1);
        sw(9'h074, 32'h74747474, 1, 0, 2);
        sw(9'h078, 32'h78787878, 1, 0, 3);

        // reset with a store request pending
        reset = 1'b1;
        drive_idle();
        sb_if.req_valid = 1'b1;
        sb_if.req_write = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        drive_idle();
        reset = 1'b0;

        for (int i = 0; i < nvec; i++) apply(i);

        // test 6: one reset cycle discards the three buffered stores
        exp_q.delete();
        drive_idle();
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("post_reset sb_count", {61'd0, sb_count}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_reset idle%0d sb_empty", i), {63'd0, sb_empty}, 64'd1);
            chk($sformatf("post_reset idle%0d dm_MemWrite", i), {63'd0, sb_if.dm_MemWrite}, 64'd0);
        end
        chk("scoreboard_left", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Small FIFO store buffer between the MEM-stage request and the single-ported datamemory.
- Stores retire into the buffer immediately; their writes go to memory later, in cycles when the memory port is otherwise unused.
- Loads go straight to datamemory. A load that hits a buffered store's address stalls until that store has drained.
- Drives datamemory's MemRead/MemWrite/a/wd/Funct3 and passes its read data back to the pipeline.

Parameters:
DEPTH, 4, number of buffered store entries (power of two, >=2)
DM_ADDRESS, 9, data memory address width
DATA_W, 32, data width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  MEM-stage memory request present
req_write  in  1  1 = store, 0 = load
req_addr  in  DM_ADDRESS  request address
req_wdata  in  DATA_W  store data
req_funct3  in  3  instruction bits 14:12 (width/sign)
req_ready  out  1  request accepted this cycle; 0 stalls the pipeline
ld_valid  out  1  load data valid this cycle
ld_data  out  DATA_W  load result
sb_count  out  $clog2(DEPTH+1)  occupied entries
sb_empty  out  1  sb_count == 0
dm_MemRead  out  1  to datamemory MemRead
dm_MemWrite  out  1  to datamemory MemWrite
dm_a  out  DM_ADDRESS  to datamemory a
dm_wd  out  DATA_W  to datamemory wd
dm_Funct3  out  3  to datamemory Funct3
dm_rd  in  DATA_W  from datamemory rd

Behaviour:
- Storage: circular FIFO of {addr, data, funct3}.
  - head and tail pointers wrap modulo DEPTH.
  - count ranges 0..DEPTH.
  - full = (count == DEPTH).
- Reset: one clock, synchronous, active-high, as stated.
  - Pointers and count go to 0. Buffered stores are discarded and never written.
  - While reset is high: req_ready=0, ld_valid=0, all dm_* outputs 0, sb_empty=1.
- hazard: req_valid & ~req_write & (some valid entry's addr == req_addr). The compare is on the full DM_ADDRESS bits.
- req_ready = ~reset & ~full & ~hazard for loads; ~reset & ~full for stores.
  - Load with full=1 and no hazard: stalls one cycle while the head drains.
- Accepted store (req_valid & req_write & req_ready):
  - Written at tail on the clock edge; tail++, count++.
  - No memory access that cycle.
- Accepted load:
  - dm_MemRead=1, dm_a=req_addr, dm_Funct3=req_funct3.
  - ld_valid=1 and ld_data=dm_rd in the same cycle (zero-latency combinational pass-through).
  - count unchanged.
- Drain: performed when count>0 and no request is accepted this cycle (idle, stalled-full, or stalled-hazard cycles).
  - Drives dm_MemWrite=1 and dm_a/dm_wd/dm_Funct3 from the head entry.
  - head++, count-- at the edge.
- At most one dm_MemRead or dm_MemWrite per cycle; never both. Otherwise dm_* = 0.
- Enqueue and drain never occur in the same cycle.
- A hazard clears once every matching entry has drained, oldest first.
- ld_valid=0 and ld_data=0 whenever no load is accepted.
- Drain order is strict FIFO.
- Back-to-back stores accumulate until the buffer is full.

Optional Feature:
- Macro: SB_FWD_EN.
- Defined:
  - A hazard load with req_funct3==3'b010 (LW) whose youngest matching entry has funct3==3'b010 (SW) is accepted.
  - It returns that entry's data: ld_valid=1 same cycle, dm_MemRead=0.
  - Search order is tail-1 backwards.
  - Forwarding is allowed even when full, but the forwarded load still counts as an accepted request, so no drain that cycle.
  - All other hazards stall as above.
- Undefined: every hazard stalls; no forwarding logic is present.

Test Plan:
1. After reset, SW 0x010/0x014/0x018/0x01C with data 0x11111111..0x44444444 back-to-back (DEPTH=4) -> sb_count 1,2,3,4; dm_MemWrite=0 throughout. A 5th SW to 0x020 sees req_ready=0 for one cycle while 0x010/0x11111111 drains, then is accepted.
2. Four idle cycles after the buffer holds four entries -> dm_MemWrite=1 for four cycles in FIFO order; sb_empty=1 afterwards.
3. SW 0x020=0xDEADBEEF, then LW 0x020 (macro off) -> req_ready=0 for one cycle with dm_MemWrite to 0x020; next cycle ld_valid=1, ld_data=0xDEADBEEF.
4. With count=2, LW 0x040 (memory holds 0x0000ABCD) -> same cycle dm_MemRead=1, ld_valid=1, ld_data=0x0000ABCD; sb_count stays 2; no write.
5. SB_FWD_EN defined: SW 0x030=0xCAFEF00D, then LW 0x030 -> ld_valid same cycle, ld_data=0xCAFEF00D, dm_MemRead=0. A following LB 0x030 stalls until drained.
6. Three stores buffered, reset high for one cycle -> sb_count=0, sb_empty=1; no dm_MemWrite for those entries ever appears.
